// File: rtl/split_assign_search.sv
// split_assign_search: LFSR-driven candidate generator for the split constraint checker.
//
// Fills a VEC_W-bit candidate from a 64-bit Galois LFSR, offers it over a valid/ready
// channel, waits for the checker's one-bit verdict and repeats until a satisfying
// candidate is seen or MAX_TRIALS verdicts have been collected.
//
// Optional feature macro: SPLIT_SEARCH_COUNT_ALL_EN
//   defined   - hits do not stop the search; it runs to MAX_TRIALS and sol_cnt counts every hit
//   undefined - the search stops at the first hit; sol_cnt is tied to 0
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        one-cycle pulse that begins a search (ignored while busy)
//   seed_load    load seed into the LFSR when not busy (seed 0 selects DEF_SEED)
//   seed         64-bit LFSR seed
//   cand_valid   candidate offered to the checker
//   cand_ready   checker accepts the candidate
//   cand_vec     candidate assignment, var_0 in the MSBs
//   res_valid    verdict strobe from the checker
//   res_x        verdict, 1 = all constraints satisfied
//   busy         search in progress
//   done         one-cycle pulse at search end
//   found        a satisfying candidate was seen (held until next start)
//   sol_vec      first satisfying candidate (held until next start)
//   trial_cnt    verdicts received in the current/last search
//   sol_cnt      satisfying verdicts (0 unless SPLIT_SEARCH_COUNT_ALL_EN)
module split_assign_search #(
    parameter int          VEC_W      = 394,
    parameter int          MAX_TRIALS = 65536,
    parameter int          CNT_W      = 32,
    parameter logic [63:0] DEF_SEED   = 64'h9E3779B97F4A7C15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             seed_load,
    input  logic [63:0]      seed,
    output logic             cand_valid,
    input  logic             cand_ready,
    output logic [VEC_W-1:0] cand_vec,
    input  logic             res_valid,
    input  logic             res_x,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [VEC_W-1:0] sol_vec,
    output logic [CNT_W-1:0] trial_cnt,
    output logic [CNT_W-1:0] sol_cnt
);
    localparam int NCHUNK = (VEC_W + 63) / 64;
    localparam int FC_W   = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    // x^64 + x^63 + x^61 + x^60 + 1 in right-shifting Galois form
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
`ifdef SPLIT_SEARCH_COUNT_ALL_EN
    localparam bit COUNT_ALL = 1'b1;
`else
    localparam bit COUNT_ALL = 1'b0;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_OFFER = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state, state_nxt;
    logic [FC_W-1:0]    fill_cnt;
    logic [63:0]        lfsr, lfsr_nxt;
    logic [VEC_W-1:0]   vec;
    logic [VEC_W+63:0]  shifted;
    logic [CNT_W-1:0]   trial_inc;
    logic               idle_like, go, verdict, fill_last, last_trial, stop;

    assign idle_like  = state == S_IDLE || state == S_DONE;
    assign go         = start && idle_like;
    assign verdict    = state == S_WAIT && res_valid;
    assign fill_last  = fill_cnt == FC_W'(NCHUNK - 1);
    assign lfsr_nxt   = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 64'h0);
    // new chunk enters at the LSB end so the oldest chunk ends up in the MSBs
    assign shifted    = {vec, lfsr};
    assign trial_inc  = &trial_cnt ? trial_cnt : trial_cnt + 1'b1;
    // widened compare so a budget of 2^CNT_W cannot wrap
    assign last_trial = 64'(trial_cnt) + 64'd1 == 64'(MAX_TRIALS);
    assign stop       = (res_x && !COUNT_ALL) || last_trial;

    // outputs decode the state register directly, so an async reset clears them at once
    assign cand_valid = state == S_OFFER;
    assign busy       = state == S_FILL || state == S_OFFER || state == S_WAIT;
    assign done       = state == S_DONE;
    assign cand_vec   = vec;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = start ? S_FILL : S_IDLE;
            S_FILL:  state_nxt = fill_last ? S_OFFER : S_FILL;
            S_OFFER: state_nxt = cand_ready ? S_WAIT : S_OFFER;
            S_WAIT:  state_nxt = res_valid ? (stop ? S_DONE : S_FILL) : S_WAIT;
            S_DONE:  state_nxt = start ? S_FILL : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= (state == S_FILL && !fill_last) ? fill_cnt + 1'b1 : '0;
        end
    end

    // seed takes effect on the same edge as a coincident start, so the fill that follows uses it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= DEF_SEED;
            vec  <= '0;
        end else if (seed_load && idle_like) begin
            lfsr <= seed == 64'h0 ? DEF_SEED : seed;
        end else if (state == S_FILL) begin
            lfsr <= lfsr_nxt;
            vec  <= shifted[VEC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trial_cnt <= '0;
            found     <= 1'b0;
            sol_vec   <= '0;
        end else if (go) begin
            trial_cnt <= '0;
            found     <= 1'b0;
            sol_vec   <= '0;
        end else if (verdict) begin
            trial_cnt <= trial_inc;
            if (res_x && !found) begin
                found   <= 1'b1;
                sol_vec <= vec;
            end
        end
    end

`ifdef SPLIT_SEARCH_COUNT_ALL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sol_cnt <= '0;
        else if (go)
            sol_cnt <= '0;
        else if (verdict && res_x && !(&sol_cnt))
            sol_cnt <= sol_cnt + 1'b1;
    end
`else
    assign sol_cnt = '0;
`endif
endmodule

// File: tb/tb_split_assign_search.sv
// tb_split_assign_search: directed bench acting as control block and checker for split_assign_search.
module tb_split_assign_search;
    localparam int          VEC_W = 394;
    localparam int          MT    = 16;
    localparam int          CNT_W = 32;
    localparam int          NCH   = 7;
    localparam logic [63:0] DEF   = 64'h9E3779B97F4A7C15;
`ifdef SPLIT_SEARCH_COUNT_ALL_EN
    localparam bit ALL = 1'b1;
`else
    localparam bit ALL = 1'b0;
`endif

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             start = 1'b0, seed_load = 1'b0, cand_ready = 1'b0, res_valid = 1'b0, res_x = 1'b0;
    logic [63:0]      seed = '0;
    logic             cand_valid, busy, done, found;
    logic [VEC_W-1:0] cand_vec, sol_vec;
    logic [CNT_W-1:0] trial_cnt, sol_cnt;

    int               nvec = 0, nbad = 0, ntr;
    logic [63:0]      m_lfsr;
    logic [VEC_W-1:0] first_vec, keep_vec;

    split_assign_search #(.VEC_W(VEC_W), .MAX_TRIALS(MT), .CNT_W(CNT_W), .DEF_SEED(DEF)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed(seed),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_vec(cand_vec),
        .res_valid(res_valid), .res_x(res_x), .busy(busy), .done(done), .found(found),
        .sol_vec(sol_vec), .trial_cnt(trial_cnt), .sol_cnt(sol_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [63:0] lstep(input logic [63:0] l);
        return (l >> 1) ^ (l[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    task automatic model_fill(output logic [VEC_W-1:0] v);
        logic [VEC_W+63:0] t;
        v = '0;
        repeat (NCH) begin
            t      = {v, m_lfsr};
            v      = t[VEC_W-1:0];
            m_lfsr = lstep(m_lfsr);
        end
    endtask

    function automatic int exp_trials(input logic [31:0] h);
        for (int i = 0; i < MT; i++)
            if (h[i] && !ALL) return i + 1;
        return MT;
    endfunction

    // runs one search; trial i (0-based) gets verdict hits[i]; trial stall_at is held in OFFER
    task automatic search(input bit ld, input logic [63:0] sd, input logic [31:0] hits,
                          input int stall_at, output int n);
        logic [VEC_W-1:0] mv, exp_sol, v0;
        logic [CNT_W-1:0] tc0;
        bit               exp_found, ok;
        int               exp_sc, w;
        start = 1'b1; seed_load = ld; seed = sd;
        tick();
        start = 1'b0; seed_load = 1'b0;
        if (ld) m_lfsr = (sd == 64'h0) ? DEF : sd;
        exp_sol = '0; exp_found = 1'b0; exp_sc = 0; n = 0;
        repeat (MT) begin
            w = 0;
            while (!cand_valid && w < 20) begin
                tick();
                w++;
            end
            if (!cand_valid) begin
                chk("cand_valid_timeout", cand_valid, 1);
                break;
            end
            model_fill(mv);
            if (n == 0) first_vec = cand_vec;
            chk("cand_vec", cand_vec, mv);
            if (n == stall_at) begin
                tc0 = trial_cnt; v0 = cand_vec; ok = 1'b1;
                repeat (20) begin
                    res_valid = 1'b1; res_x = 1'b1; start = 1'b1;
                    tick();
                    ok &= cand_valid && busy && cand_vec == v0;
                end
                res_valid = 1'b0; res_x = 1'b0; start = 1'b0;
                chk("stall_stable", ok, 1);
                chk("stall_trial_cnt", trial_cnt, tc0);
            end
            cand_ready = 1'b1;
            tick();
            cand_ready = 1'b0; res_valid = 1'b1; res_x = hits[n];
            tick();
            res_valid = 1'b0; res_x = 1'b0;
            if (hits[n]) begin
                if (!exp_found) exp_sol = mv;
                exp_found = 1'b1;
                exp_sc++;
            end
            n++;
            if (done) break;
        end
        chk("trials", n, exp_trials(hits));
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("trial_cnt", trial_cnt, exp_trials(hits));
        chk("found", found, exp_found);
        chk("sol_vec", sol_vec, exp_sol);
        chk("sol_cnt", sol_cnt, ALL ? exp_sc : 0);
        tick();
        chk("done_pulse", done, 0);
        chk("found_hold", found, exp_found);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_cand_valid", cand_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_trial_cnt", trial_cnt, 0);
        chk("rst_sol_cnt", sol_cnt, 0);
        chk("rst_cand_vec", cand_vec, 0);
        chk("rst_sol_vec", sol_vec, 0);
        rst_n = 1'b1;
        tick();

        // abort by reset while a candidate is on offer
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !cand_valid; i++) tick();
        chk("pre_abort_valid", cand_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_cand_valid", cand_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_found", found, 0);
        chk("abort_trial_cnt", trial_cnt, 0);
        tick();
        rst_n = 1'b1;
        m_lfsr = DEF;
        tick();

        // every verdict satisfying, seed 1
        search(1'b1, 64'd1, 32'hFFFF_FFFF, -1, ntr);
        // no hits: runs the whole budget, then continuity of the LFSR into the next search
        search(1'b1, 64'd5, 32'h0, -1, ntr);
        search(1'b0, 64'd0, 32'h1, -1, ntr);
        // hits on 3rd and 5th verdicts
        search(1'b1, 64'h1234, 32'h14, -1, ntr);
        // seed 0 behaves as DEF_SEED; stall in OFFER with spurious verdicts and starts
        search(1'b1, 64'd0, 32'h4, 1, ntr);
        keep_vec = first_vec;
        search(1'b1, DEF, 32'h1, -1, ntr);
        chk("def_seed_equiv", first_vec, keep_vec);
        search(1'b1, 64'd0, 32'h1, -1, ntr);
        chk("reseed_repeat", first_vec, keep_vec);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
